// File: rtl/nibble_tx.sv
// nibble_tx: buffers 12-bit samples in a 4-entry FIFO and sends each word as
// three nibbles (bits [3:0], then [7:4], then [11:8]) over a 4-bit link.
// Each nibble is framed by setup, strobe and hold intervals. After the third
// nibble, a gap interval follows.
module nibble_tx #(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STB_CYC    = 1,
  parameter int unsigned HOLD_CYC   = 2,
  parameter int unsigned GAP_CYC    = 1,
  // Value WordCount takes while reset is asserted (normally zero).
  parameter logic [15:0] WCOUNT_RST = 16'h0000
) (
  input  logic        ExtClk,
  input  logic        ExtResetn,
  input  logic        Enable,
  input  logic [11:0] SampleIn,
  input  logic        SampleInValid,
  output logic        SampleInReady,
  output logic [3:0]  DataOut,
  output logic [1:0]  ReadPhase,
  output logic        ReadPulse,
  output logic        Busy,
  output logic [15:0] WordCount
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_GAP
  } state_t;

  // Counter reload values: a state lasting N cycles counts N-1 down to 0.
  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STB_LD   = 8'(STB_CYC - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);
  localparam logic [7:0] GAP_LD   = 8'(GAP_CYC - 1);

  // FIFO storage and bookkeeping
  logic [11:0] mem_q [4];
  logic [1:0]  wptr_q, wptr_d;
  logic [1:0]  rptr_q, rptr_d;
  logic [2:0]  occ_q, occ_d;
  logic        push, pop;

  // Transmit FSM state
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [11:0] shadow_q, shadow_d;
  logic [3:0]  data_q, data_d;
  logic [1:0]  phase_q, phase_d;
  logic        pulse_q, pulse_d;
  logic [15:0] wc_q, wc_d;

  // Ready depends only on registered occupancy. A pop in the same cycle
  // therefore cannot make room for a push until the following cycle.
  assign SampleInReady = (occ_q != 3'd4);
  assign push          = SampleInValid && SampleInReady;
  assign pop           = (state_q == S_IDLE) && (occ_q != 3'd0) && Enable;

  // FIFO pointer and occupancy next-state; a simultaneous push and pop leave occupancy unchanged
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    if (push) wptr_d = wptr_q + 2'd1;
    if (pop)  rptr_d = rptr_q + 2'd1;
    if (push && !pop)      occ_d = occ_q + 3'd1;
    else if (pop && !push) occ_d = occ_q - 3'd1;
  end

  // FIFO pointer and occupancy registers
  always_ff @(posedge ExtClk or negedge ExtResetn) begin
    if (!ExtResetn) begin
      wptr_q <= 2'd0;
      rptr_q <= 2'd0;
      occ_q  <= 3'd0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
    end
  end

  // FIFO storage; contents are meaningless until written, so it has no reset
  always_ff @(posedge ExtClk) begin
    if (push) mem_q[wptr_q] <= SampleIn;
  end

  // FSM next-state: sequences setup/strobe/hold per nibble, then gap
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    phase_d  = phase_q;
    wc_d     = wc_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          shadow_d = mem_q[rptr_q];
          data_d   = mem_q[rptr_q][3:0];
          phase_d  = 2'd0;
          cnt_d    = SETUP_LD;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = STB_LD;
          state_d = S_STROBE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_STROBE: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = HOLD_LD;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == 8'd0) begin
          if (phase_q == 2'd2) begin
            wc_d    = wc_q + 16'd1;
            cnt_d   = GAP_LD;
            state_d = S_GAP;
          end else begin
            phase_d = phase_q + 2'd1;
            data_d  = (phase_q == 2'd0) ? shadow_q[7:4] : shadow_q[11:8];
            cnt_d   = SETUP_LD;
            state_d = S_SETUP;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == 8'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    pulse_d = (state_d == S_STROBE);
  end

  // FSM and output registers; reset drops the strobe and discards the partial word
  always_ff @(posedge ExtClk or negedge ExtResetn) begin
    if (!ExtResetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      shadow_q <= 12'd0;
      data_q   <= 4'd0;
      phase_q  <= 2'd0;
      pulse_q  <= 1'b0;
      wc_q     <= WCOUNT_RST;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      phase_q  <= phase_d;
      pulse_q  <= pulse_d;
      wc_q     <= wc_d;
    end
  end

  assign DataOut   = data_q;
  assign ReadPhase = phase_q;
  assign ReadPulse = pulse_q;
  assign WordCount = wc_q;
  assign Busy      = (state_q != S_IDLE) || (occ_q != 3'd0);

endmodule

// File: doc/nibble_tx.md
NIBBLE_TX -- requirements
Module: nibble_tx

Interface
REQ-001 Parameter SETUP_CYC, default 2: cycles nibble/phase are stable before ReadPulse rises; legal range 1..255.
REQ-002 Parameter STB_CYC, default 1: cycles ReadPulse stays high per nibble; legal range 1..255.
REQ-003 Parameter HOLD_CYC, default 2: cycles nibble/phase stay stable after ReadPulse falls; legal range 1..255.
REQ-004 Parameter GAP_CYC, default 1: idle cycles after the third nibble before the next word can start; legal range 1..255.
REQ-005 ExtClk  in  1  sole clock; all logic rising-edge.
REQ-006 ExtResetn  in  1  reset, asynchronous, active-low.
REQ-007 Enable  in  1  1 = new words may be popped from the FIFO.
REQ-008 SampleIn  in  12  sample word to transmit.
REQ-009 SampleInValid  in  1  SampleIn is valid this cycle.
REQ-010 SampleInReady  out  1  FIFO can accept a word; a word is pushed when Valid and Ready are both 1.
REQ-011 DataOut  out  4  nibble driven to the parallel link.
REQ-012 ReadPhase  out  2  nibble index: 0 = bits[3:0], 1 = bits[7:4], 2 = bits[11:8].
REQ-013 ReadPulse  out  1  strobe; receiver captures DataOut while high.
REQ-014 Busy  out  1  1 when the FSM is not IDLE or the FIFO is non-empty.
REQ-015 WordCount  out  16  count of completed words.

Function
REQ-016 The block SHALL buffer input words in a 4-entry FIFO; SampleInReady = not full, derived from registered occupancy only.
REQ-017 The FSM SHALL have states IDLE, SETUP, STROBE, HOLD, GAP, driven by one 8-bit down-counter.
REQ-018 In IDLE with FIFO non-empty and Enable=1 at cycle T, the block SHALL pop one word into a 12-bit shadow register; at T+1, DataOut=word[3:0], ReadPhase=0, and the state is SETUP.
REQ-019 SETUP SHALL last SETUP_CYC cycles, STROBE STB_CYC cycles, and HOLD HOLD_CYC cycles; ReadPulse is registered and is 1 only in STROBE.
REQ-020 On HOLD exit with ReadPhase<2, the block SHALL increment ReadPhase, drive the next nibble on DataOut in the same cycle, and re-enter SETUP.
REQ-021 On HOLD exit with ReadPhase=2, the block SHALL increment WordCount (wrapping 0xFFFF->0x0000) and enter GAP for GAP_CYC cycles, then IDLE.
REQ-022 Word period SHALL be 1+3*(SETUP_CYC+STB_CYC+HOLD_CYC)+GAP_CYC cycles; with defaults this is 17.
REQ-023 DataOut and ReadPhase SHALL change only on SETUP entry and SHALL hold their last values in IDLE and GAP; ReadPhase never equals 3.
REQ-024 Enable deasserted mid-word SHALL NOT abort the word; the word completes, and no further pop occurs until Enable=1.
REQ-025 A push and a pop in the same cycle SHALL leave occupancy unchanged and SHALL preserve FIFO order.
REQ-026 A push offered while the FIFO is full SHALL be ignored, because Ready=0; a pop in that cycle does not raise Ready until the next cycle.
REQ-027 Pointers SHALL be 2-bit, wrapping modulo 4, with a separate 3-bit occupancy count.

Reset
REQ-028 While ExtResetn=0, all outputs SHALL be: DataOut=0, ReadPhase=0, ReadPulse=0, Busy=0, WordCount=0, SampleInReady=1.
REQ-029 Reset SHALL set the FSM to IDLE, the FIFO to empty, and the counter to 0.
REQ-030 Reset asserted mid-word SHALL drop ReadPulse immediately, asynchronously, and SHALL discard the partial word and all FIFO contents.
REQ-031 After release, the first pop SHALL be possible on the first rising edge with ExtResetn=1.

Verification
REQ-032 Defaults, push 0xABC once with Enable=1: DataOut/ReadPhase sequence C/0, B/1, A/2; each ReadPulse high 1 cycle, 2 cycles after the nibble changes; WordCount=1; Busy falls 17 cycles after the pop.
REQ-033 Push 6 words back-to-back while Enable=0: SampleInReady falls after the 4th accepted push; words 5-6 are not accepted; after Enable=1, exactly 4 words are output in push order.
REQ-034 Enable=0 during phase 1 of word 0x123: the word completes (3, 2, 1); the next queued word starts only 1 cycle after Enable returns to 1.
REQ-035 ExtResetn pulsed low during STROBE of phase 1: ReadPulse=0 and all outputs at reset values within the reset cycle; FIFO is empty; no further strobes occur until a new push.
REQ-036 With SETUP_CYC=STB_CYC=HOLD_CYC=GAP_CYC=1 and continuous streaming: word period is 11 cycles; WordCount wraps from 0xFFFF to 0 after 65536 words, checked with a preloaded count.
